// File: rtl/shl_iter.sv
// shl_iter: iterative left rotator / logical left shifter, one bit per clock.
// A request is accepted from IDLE or DONE. The operand is then shifted
// `amount` times in SHIFT, and completion is flagged by a one-cycle `done`
// in DONE. `carry` holds the last bit that left the MSB.
module shl_iter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] RA,
    input  logic [AMT_W-1:0] amount,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AMT_W-1:0] cnt;
    logic             mode_r;
    logic             accept;

    // Single-step left move: the MSB wraps into bit 0 for a rotate,
    // or a zero enters bit 0 for a logical shift.
    function automatic logic [WIDTH-1:0] step_left(input logic [WIDTH-1:0] v,
                                                   input logic             zero_fill);
        return {v[WIDTH-2:0], (zero_fill ? 1'b0 : v[WIDTH-1])};
    endfunction

    // State register; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    // Back-to-back: a new request is taken straight from DONE.
                    accept    = 1'b1;
                    state_nxt = (amount != '0) ? SHIFT : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand, carry, remaining-count and mode registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            mode_r <= 1'b0;
        end else if (accept) begin
            out    <= RA;
            carry  <= 1'b0;
            cnt    <= amount;
            mode_r <= mode;
        end else if (state == SHIFT) begin
            out   <= step_left(out, mode_r);
            carry <= out[WIDTH-1];
            cnt   <= cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_shl_iter.sv
// tb_shl_iter: directed bench for the iterative left shifter/rotator.
module tb_shl_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] RA;
    logic [3:0]  amount;
    logic        mode;
    logic [15:0] out;
    logic        carry;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] hist [0:40];

    shl_iter #(.WIDTH(16), .AMT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .RA     (RA),
        .amount (amount),
        .mode   (mode),
        .out    (out),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    // Inputs are scrambled right after the accept edge.
    task automatic launch(input logic [15:0] ra, input logic [3:0] amt, input logic md);
        RA     = ra;
        amount = amt;
        mode   = md;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        RA     = 16'hDEAD;
        amount = 4'd7;
        mode   = ~md;
    endtask

    // Samples each cycle after the accept at the negedge until done.
    // Leaves the bench at the negedge of the DONE cycle.
    // intr_k > 0 drives an ignored start (RA=0xFFFF) across the edge after cycle intr_k.
    task automatic wait_done(input string tag, input int n, input logic [15:0] exp_out,
                             input logic exp_c, input int intr_k);
        int k;
        int bcnt;
        int ovl;
        k    = 0;
        bcnt = 0;
        ovl  = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            hist[k] = out;
            if (busy) bcnt++;
            if (busy && done) ovl++;
            if (done) break;
            if (intr_k > 0 && k == intr_k) begin
                RA     = 16'hFFFF;
                amount = 4'd3;
                mode   = 1'b1;
                start  = 1'b1;
            end
            if (intr_k > 0 && k == intr_k + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, ".latency"}, k, n + 1);
        chk({tag, ".busy_cycles"}, bcnt, n);
        chk({tag, ".busy_done_overlap"}, ovl, 0);
        chk({tag, ".out"}, out, exp_out);
        chk({tag, ".carry"}, carry, exp_c);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        RA     = 16'h0;
        amount = 4'd0;
        mode   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.out", out, 16'h0);
        chk("reset.carry", carry, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Rotate 0x8001 left by 1.
        launch(16'h8001, 4'd1, 1'b0);
        wait_done("rot1", 1, 16'h0003, 1'b1, 0);
        @(negedge clk);
        chk("rot1.idle_done", done, 1'b0);
        chk("rot1.idle_hold_out", out, 16'h0003);
        chk("rot1.idle_hold_carry", carry, 1'b1);
        @(negedge clk);

        // Logical shift 0x8001 left by 4, with intermediate values.
        launch(16'h8001, 4'd4, 1'b1);
        wait_done("shl4", 4, 16'h0010, 1'b0, 0);
        chk("shl4.step1", hist[1], 16'h8001);
        chk("shl4.step2", hist[2], 16'h0002);
        chk("shl4.step3", hist[3], 16'h0004);
        chk("shl4.step4", hist[4], 16'h0008);
        @(negedge clk);

        // Zero amount passes the operand through.
        launch(16'h1234, 4'd0, 1'b0);
        wait_done("amt0", 0, 16'h1234, 1'b0, 0);
        @(negedge clk);

        // Full wrap (rotate right by 1) with an ignored start mid-operation,
        // then a back-to-back request taken in the DONE cycle.
        launch(16'h1234, 4'd15, 1'b0);
        wait_done("wrap15", 15, 16'h091A, 1'b0, 2);
        launch(16'h0001, 4'd2, 1'b0);
        wait_done("b2b", 2, 16'h0004, 1'b0, 0);
        @(negedge clk);

        // Logical shift by 15 drops all but bit 0; last bit out is bit 1.
        launch(16'hC003, 4'd15, 1'b1);
        wait_done("shl15", 15, 16'h8000, 1'b1, 0);
        @(negedge clk);

        // Reset in the middle of an 8-step operation.
        launch(16'hA5A5, 4'd8, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst.mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst.out", out, 16'h0);
        chk("rst.carry", carry, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        begin
            int seen;
            seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            chk("rst.no_done", seen, 0);
        end
        launch(16'h0F00, 4'd4, 1'b0);
        wait_done("post_rst", 4, 16'hF000, 1'b0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
